// File: rtl/uni_ctrl_multiciclo.sv
// uni_ctrl_multiciclo: multi-cycle MIPS control FSM (Moore) with memory stall/timeout and illegal-opcode flag
module uni_ctrl_multiciclo #(
    parameter int OP_W        = 6,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [OP_W-1:0]    Op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               Branch,
    output logic [1:0]         PCSrc,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemToWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemToReg,
    output logic               RegToWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] AluOp,
    output logic               illegal_op,
    output logic               mem_err
);
    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC_R, S_ALUWB, S_BEQ, S_ADDI_EX, S_ADDI_WB, S_JUMP
    } state_t;

    state_t     r_state, w_next;
    logic [7:0] r_cnt;
    logic       w_mem_st, w_timeout, w_illegal;

    assign w_mem_st  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // the timeout fires on the MEM_TIMEOUT-th stalled cycle; a completing cycle never times out
    assign w_timeout = w_mem_st && !mem_ready && (r_cnt == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            illegal_op <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_mem_st && !mem_ready && !w_timeout) ? r_cnt + 8'd1 : 8'd0;
            if (w_illegal) illegal_op <= 1'b1;
            if (w_timeout) mem_err <= 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_illegal  = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = 2'b00;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemToWrite = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemToReg   = 1'b0;
        RegToWrite = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        AluOp      = '0;
        case (r_state)
            S_IDLE: w_next = en ? S_FETCH : S_IDLE;
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
                w_next  = mem_ready ? S_DECODE : (w_timeout ? S_IDLE : S_FETCH);
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_R:         w_next = S_EXEC_R;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_ADDI:      w_next = S_ADDI_EX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                w_next  = mem_ready ? S_MEMWB : (w_timeout ? S_FETCH : S_MEMRD);
            end
            S_MEMWB: begin
                RegToWrite = 1'b1;
                MemToReg   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                MemToWrite = 1'b1;
                IorD       = 1'b1;
                w_next     = (mem_ready || w_timeout) ? S_FETCH : S_MEMWR;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                AluOp   = ALUOP_W'(2'b10);
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegToWrite = 1'b1;
                RegDst     = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 1'b1;
                AluOp   = ALUOP_W'(2'b01);
                Branch  = 1'b1;
                PCSrc   = 2'b01;
                w_next  = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegToWrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
                w_next  = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule
